mem_stage_dm: RTL and testbench
===============================

// Module: mem_stage_dm
// PURPOSE
//  - Consumer end of the E/M pipeline register: M-stage data memory plus M/W pipeline register.
//  - Performs MIPS stores (sw/sh/sb) and loads (lw/lh/lhu/lb/lbu) using instr_M, data_alu_M and writedata_M.
//  - Registers the results, with PC and control fields, into W-stage outputs for the register-file writeback mux.
// PARAMETERS
//  MEM_WORDS  1024  number of 32-bit data memory words (4 KB)
//  IDX_W      10    word-index width, log2(MEM_WORDS); index = data_alu_M[IDX_W+1:2]
// PORTS
//  clk           in   1   single clock, all state updates on posedge
//  reset         in   1   synchronous, active-low; reset==0 sampled at posedge clears all state
//  instr_M       in   32  M-stage instruction; opcode instr_M[31:26] selects the memory operation
//  data_alu_M    in   32  ALU result: byte address for loads and stores, pass-through value otherwise
//  writedata_M   in   32  store data, already forwarded
//  writereg_M    in   5   destination register number
//  pcout_M       in   32  PC of the M-stage instruction
//  pcchu_M       in   32  PC+8 link value
//  movz_M_output in   1   movz condition flag from E
//  instr_W       out  32  registered instr_M
//  data_alu_W    out  32  registered data_alu_M
//  data_mem_W    out  32  registered, extended load data; 0 for non-loads
//  writereg_W    out  5   registered writereg_M
//  pcout_W       out  32  registered pcout_M
//  pcchu_W       out  32  registered pcchu_M
//  movz_W        out  1   registered movz_M_output
// BEHAVIOUR
//  - Reset, when reset==0 at posedge: all W outputs go to 0 and all MEM_WORDS memory words go to 0. No store occurs that cycle, even if instr_M is a store.
//  - Opcodes: lw 6'h23, lh 6'h21, lhu 6'h25, lb 6'h20, lbu 6'h24, sw 6'h2b, sh 6'h29, sb 6'h28.
//  - Any other opcode is a non-memory op: no memory write and data_mem_W<=0.
//  - Address: idx=data_alu_M[IDX_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 4 KB.
//    - Word ops ignore addr[1:0].
//    - Half ops use addr[1]: 0 selects bits [15:0], 1 selects bits [31:16]. addr[0] is ignored.
//    - Byte ops use addr[1:0] to select lane addr*8+7 : addr*8.
//  - Store, performed at the posedge with reset==1:
//    - sw writes the whole word.
//    - sh writes writedata_M[15:0] into the selected half; the other half is preserved.
//    - sb writes writedata_M[7:0] into the selected byte; the other bytes are preserved.
//  - Store display: on each store, $display("%d@%h: *%h <= %h", $time, pcout_M, {data_alu_M[31:2],2'b00}, merged_word).
//    - merged_word is the full 32-bit word after the write.
//  - Load: the memory read is combinational on idx. The extended value is captured into data_mem_W at the same posedge, giving 1-cycle latency M->W.
//    - lh and lb sign-extend.
//    - lhu and lbu zero-extend.
//  - Store followed by load to the same word in the next cycle: the load returns the new data, because the write committed at the prior edge.
//  - Non-load instructions: data_mem_W=0.
//  - Pass-through fields: every W output other than data_mem_W is updated each posedge with reset==1 from its M input. There is no stall or flush port; a bubble arrives as instr_M=0, an sll nop that does not write memory.
//  - Reset asserted mid-stream: takes effect at that edge. The following edge with reset==1 resumes normal operation using the then-present M inputs.
// STRUCTURE
//  - Shared package/header mips_defs holds:
//    - opcode localparams: OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
//    - the MEM_WORDS default
//  - Sub-module dm_ram: MEM_WORDS x 32 array.
//    - Inputs: clk, reset, we, idx, wdata_merged; output: rdata (combinational).
//    - Byte/half merge and load extension logic live in mem_stage_dm.
// TESTING
//  - Reset: hold reset=0 for 2 cycles with instr_M=sw.
//    - Expect all W outputs 0.
//    - A later lw from any address returns 0.
//    - No $display output.
//  - sw then lw: sw with addr 0x10, data 0x12345678, then lw with addr 0x10.
//    - Expect data_mem_W=0x12345678 one cycle after the lw.
//    - Expect display "*00000010 <= 12345678".
//  - Byte and half lanes: sw 0xAABBCCDD to addr 0x20, then sb 0x11 to addr 0x21.
//    - lw addr 0x20 -> 0xAABB11DD.
//    - lb addr 0x23 -> 0xFFFFFFAA.
//    - lbu addr 0x23 -> 0x000000AA.
//    - lh addr 0x22 -> 0xFFFFAABB.
//    - lhu addr 0x20 -> 0x000011DD.
//  - sh preserve: sh 0xBEEF to addr 0x22 over the word 0xAABB11DD.
//    - lw addr 0x20 -> 0xBEEF11DD.
//  - Wrap: sw 0xCAFEF00D to addr 0x00001004, then lw addr 0x4 -> 0xCAFEF00D.
//  - Pass-through: addu with data_alu_M=0x7, writereg_M=5, pcout_M=0x3004, movz_M_output=1.
//    - Next cycle: data_alu_W=7, writereg_W=5, pcout_W=0x3004, movz_W=1, data_mem_W=0.
//    - Memory is unchanged.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS definitions for the M stage: memory opcodes and the data-memory depth.
package mips_defs;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  localparam int DM_MEM_WORDS = 1024;
  localparam int DM_IDX_W     = 10;
endpackage

// File: rtl/dm_ram.sv
// Word-wide data memory: combinational read, synchronous write, synchronous clear on reset.
import mips_defs::*;

module dm_ram #(
  parameter int MEM_WORDS = DM_MEM_WORDS,
  parameter int IDX_W     = DM_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata_merged,
  output logic [31:0]      rdata
);
  logic [31:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[idx] <= wdata_merged;
    end
  end

  assign rdata = mem_q[idx];
endmodule

// File: rtl/mem_stage_dm.sv
// M stage: byte/half/word store merge and load extension around dm_ram, plus the M/W register.
// Loads and pass-through fields reach W one cycle after M; there is no stall or flush.
import mips_defs::*;

module mem_stage_dm #(
  parameter int MEM_WORDS = DM_MEM_WORDS,
  parameter int IDX_W     = DM_IDX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_M,
  input  logic [31:0] data_alu_M,
  input  logic [31:0] writedata_M,
  input  logic [4:0]  writereg_M,
  input  logic [31:0] pcout_M,
  input  logic [31:0] pcchu_M,
  input  logic        movz_M_output,
  output logic [31:0] instr_W,
  output logic [31:0] data_alu_W,
  output logic [31:0] data_mem_W,
  output logic [4:0]  writereg_W,
  output logic [31:0] pcout_W,
  output logic [31:0] pcchu_W,
  output logic        movz_W
);
  logic [5:0]       opcode;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic             is_store;
  logic [31:0]      rdata;
  logic [31:0]      wdata_merged;
  logic [15:0]      half_sel;
  logic [7:0]       byte_sel;
  logic [31:0]      load_val;

  logic [31:0] instr_d, instr_q, data_alu_d, data_alu_q, data_mem_d, data_mem_q;
  logic [31:0] pcout_d, pcout_q, pcchu_d, pcchu_q;
  logic [4:0]  writereg_d, writereg_q;
  logic        movz_d, movz_q;

  assign opcode = instr_M[31:26];
  assign lane   = data_alu_M[1:0];
  assign idx    = data_alu_M[IDX_W+1:2];

  always_comb begin
    is_store = 1'b0;
    case (opcode)
      OP_SW, OP_SH, OP_SB: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  end

  dm_ram #(.MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)) u_dm_ram (
    .clk          (clk),
    .reset        (reset),
    .we           (is_store & reset),
    .idx          (idx),
    .wdata_merged (wdata_merged),
    .rdata        (rdata)
  );

  // Sub-word stores read-modify-write the addressed word so untouched lanes survive.
  always_comb begin
    wdata_merged = rdata;
    case (opcode)
      OP_SW: wdata_merged = writedata_M;
      OP_SH: begin
        if (lane[1]) wdata_merged[31:16] = writedata_M[15:0];
        else         wdata_merged[15:0]  = writedata_M[15:0];
      end
      OP_SB: begin
        case (lane)
          2'd0:    wdata_merged[7:0]   = writedata_M[7:0];
          2'd1:    wdata_merged[15:8]  = writedata_M[7:0];
          2'd2:    wdata_merged[23:16] = writedata_M[7:0];
          default: wdata_merged[31:24] = writedata_M[7:0];
        endcase
      end
      default: wdata_merged = rdata;
    endcase
  end

  always_comb begin
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    byte_sel = rdata[{lane, 3'b000} +: 8];
    load_val = '0;
    case (opcode)
      OP_LW:   load_val = rdata;
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'h0000, half_sel};
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'h000000, byte_sel};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    instr_d    = instr_M;
    data_alu_d = data_alu_M;
    data_mem_d = load_val;
    writereg_d = writereg_M;
    pcout_d    = pcout_M;
    pcchu_d    = pcchu_M;
    movz_d     = movz_M_output;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q    <= '0;
      data_alu_q <= '0;
      data_mem_q <= '0;
      writereg_q <= '0;
      pcout_q    <= '0;
      pcchu_q    <= '0;
      movz_q     <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      data_alu_q <= data_alu_d;
      data_mem_q <= data_mem_d;
      writereg_q <= writereg_d;
      pcout_q    <= pcout_d;
      pcchu_q    <= pcchu_d;
      movz_q     <= movz_d;
    end
  end

  assign instr_W    = instr_q;
  assign data_alu_W = data_alu_q;
  assign data_mem_W = data_mem_q;
  assign writereg_W = writereg_q;
  assign pcout_W    = pcout_q;
  assign pcchu_W    = pcchu_q;
  assign movz_W     = movz_q;

`ifndef SYNTHESIS
  // Store trace for simulation logs; merged word is the value being committed.
  always @(posedge clk) begin
    if (reset && is_store) begin
      $display("%d@%h: *%h <= %h", $time, pcout_M, {data_alu_M[31:2], 2'b00}, wdata_merged);
    end
  end
`endif
endmodule

// File: tb/tb_mem_stage_dm.sv
// Bench for mem_stage_dm: byte-addressed reference memory model, per-cycle compare, literal spot checks.
import mips_defs::*;

module tb_mem_stage_dm;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_M = '0, data_alu_M = '0, writedata_M = '0, pcout_M = '0, pcchu_M = '0;
  logic [4:0]  writereg_M = '0;
  logic        movz_M_output = 1'b0;
  logic [31:0] instr_W, data_alu_W, data_mem_W, pcout_W, pcchu_W;
  logic [4:0]  writereg_W;
  logic        movz_W;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mb [4096];
  logic [31:0] e_instr, e_alu, e_mem, e_pc, e_pcchu;
  logic [4:0]  e_wreg;
  logic        e_movz;
  bit          e_vld = 1'b0;

  always #5 clk = ~clk;

  mem_stage_dm dut (
    .clk(clk), .reset(reset), .instr_M(instr_M), .data_alu_M(data_alu_M),
    .writedata_M(writedata_M), .writereg_M(writereg_M), .pcout_M(pcout_M),
    .pcchu_M(pcchu_M), .movz_M_output(movz_M_output), .instr_W(instr_W),
    .data_alu_W(data_alu_W), .data_mem_W(data_mem_W), .writereg_W(writereg_W),
    .pcout_W(pcout_W), .pcchu_W(pcchu_W), .movz_W(movz_W)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference memory is a flat 4 KB byte array; addresses wrap by truncation to 12 bits.
  function automatic logic [31:0] ld_bytes(input logic [11:0] a, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mb[a + 12'(k)];
    return v;
  endfunction

  task automatic st_bytes(input logic [11:0] a, input int n, input logic [31:0] d);
    for (int k = 0; k < n; k++) mb[a + 12'(k)] = d[8*k +: 8];
  endtask

  task automatic op(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [4:0] wreg, input logic [31:0] pc, input logic mz,
                    input logic [25:0] low, input logic rst_n);
    logic [11:0] a, aw, ah;
    logic [31:0] v;
    @(negedge clk);
    instr_M = {opc, low}; data_alu_M = addr; writedata_M = wd; writereg_M = wreg;
    pcout_M = pc; pcchu_M = pc + 32'd8; movz_M_output = mz; reset = rst_n;
    @(posedge clk);
    a  = addr[11:0];
    aw = {addr[11:2], 2'b00};
    ah = {addr[11:1], 1'b0};
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
      e_instr = '0; e_alu = '0; e_mem = '0; e_wreg = '0; e_pc = '0; e_pcchu = '0; e_movz = 1'b0;
    end else begin
      v = '0;
      case (opc)
        OP_LW:  v = ld_bytes(aw, 4);
        OP_LH:  begin v = ld_bytes(ah, 2); if (v[15]) v = v | 32'hFFFF0000; end
        OP_LHU: v = ld_bytes(ah, 2);
        OP_LB:  begin v = ld_bytes(a, 1); if (v[7]) v = v | 32'hFFFFFF00; end
        OP_LBU: v = ld_bytes(a, 1);
        OP_SW:  st_bytes(aw, 4, wd);
        OP_SH:  st_bytes(ah, 2, wd);
        OP_SB:  st_bytes(a, 1, wd);
        default: v = '0;
      endcase
      e_instr = {opc, low}; e_alu = addr; e_mem = v; e_wreg = wreg;
      e_pc = pc; e_pcchu = pc + 32'd8; e_movz = mz;
    end
    e_vld = 1'b1;
  endtask

  task automatic simple(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] wd);
    op(opc, addr, wd, 5'($urandom), $urandom, 1'($urandom), 26'($urandom), 1'b1);
  endtask

  always @(negedge clk) begin
    if (e_vld) begin
      chk("instr_W", instr_W, e_instr);
      chk("data_alu_W", data_alu_W, e_alu);
      chk("data_mem_W", data_mem_W, e_mem);
      chk("writereg_W", {27'd0, writereg_W}, {27'd0, e_wreg});
      chk("pcout_W", pcout_W, e_pc);
      chk("pcchu_W", pcchu_W, e_pcchu);
      chk("movz_W", {31'd0, movz_W}, {31'd0, e_movz});
    end
  end

  logic [5:0] ops [10];

  initial begin
    ops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB, 6'h00, 6'h0f};

    op(OP_SW, 32'h10, 32'hDEADBEEF, 5'd3, 32'h100, 1'b1, 26'h1, 1'b0);
    op(OP_SW, 32'h10, 32'hDEADBEEF, 5'd3, 32'h104, 1'b1, 26'h1, 1'b0);
    #2;
    chk("rst_instr_W", instr_W, 32'h0);
    chk("rst_pcout_W", pcout_W, 32'h0);
    simple(OP_LW, 32'h10, 32'h0);
    #2 chk("rst_lw", data_mem_W, 32'h0);

    simple(OP_SW, 32'h10, 32'h12345678);
    simple(OP_LW, 32'h10, 32'h0);
    #2 chk("sw_lw", data_mem_W, 32'h12345678);

    simple(OP_SW, 32'h20, 32'hAABBCCDD);
    simple(OP_SB, 32'h21, 32'h00000011);
    simple(OP_LW, 32'h20, 32'h0);  #2 chk("lw_20", data_mem_W, 32'hAABB11DD);
    simple(OP_LB, 32'h23, 32'h0);  #2 chk("lb_23", data_mem_W, 32'hFFFFFFAA);
    simple(OP_LBU, 32'h23, 32'h0); #2 chk("lbu_23", data_mem_W, 32'h000000AA);
    simple(OP_LH, 32'h22, 32'h0);  #2 chk("lh_22", data_mem_W, 32'hFFFFAABB);
    simple(OP_LHU, 32'h20, 32'h0); #2 chk("lhu_20", data_mem_W, 32'h000011DD);

    simple(OP_SH, 32'h22, 32'h0000BEEF);
    simple(OP_LW, 32'h20, 32'h0);  #2 chk("sh_keep", data_mem_W, 32'hBEEF11DD);

    simple(OP_SW, 32'h00001004, 32'hCAFEF00D);
    simple(OP_LW, 32'h4, 32'h0);   #2 chk("wrap", data_mem_W, 32'hCAFEF00D);

    op(6'h00, 32'h7, 32'hFFFFFFFF, 5'd5, 32'h3004, 1'b1, 26'h21, 1'b1);
    #2;
    chk("pt_alu", data_alu_W, 32'h7);
    chk("pt_wreg", {27'd0, writereg_W}, 32'd5);
    chk("pt_pc", pcout_W, 32'h3004);
    chk("pt_movz", {31'd0, movz_W}, 32'd1);
    chk("pt_mem", data_mem_W, 32'h0);
    simple(OP_LW, 32'h4, 32'h0);   #2 chk("pt_unchanged", data_mem_W, 32'hCAFEF00D);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] ad;
      ad = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      op(ops[$urandom_range(0, 9)], ad, $urandom, 5'($urandom), $urandom, 1'($urandom),
         26'($urandom), ($urandom_range(0, 59) != 0));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
